clint_smp: RTL

- Core-local interruptor for the SMP hart cluster; sits directly upstream of the cluster and drives its per-hart timer and software interrupt inputs plus the shared 64-bit time value.
- Holds one free-running 64-bit mtime, per-hart 64-bit mtimecmp and per-hart msip bits.
- Registers are reached through a simple 32-bit word-access slave port from the memory-mapped I/O decoder.

---
 rtl/clint_pkg.sv | 27 ++
 rtl/clint_tick_gen.sv | 44 ++++
 rtl/clint_smp.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants and types for the SMP core-local interruptor.
//   Address-map bases (byte offsets inside the 64 KiB CLINT window), the
//   mtimecmp reset value and the register-region select type used by the
//   decoder in clint_smp.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Which register region a request address falls into.
  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MSIP     = 2'd1,
    SEL_MTIMECMP = 2'd2,
    SEL_MTIME    = 2'd3
  } clint_sel_e;

  // True when addr addresses the 32-bit word at base (byte lanes ignored).
  function automatic logic word_match(input logic [15:0] addr, input logic [15:0] base);
    return (addr[15:2] == base[15:2]);
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: mtime prescaler.
//   Counts 0..MTIME_DIV-1 and wraps; tick_o is high on the cycle the count
//   equals MTIME_DIV-1, so with MTIME_DIV=1 it is high every cycle.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (count returns to 0)
//   tick_o  one-cycle mtime increment strobe
module clint_tick_gen #(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  // A 1-bit counter is kept even for MTIME_DIV=1; it simply never leaves 0.
  localparam int unsigned CW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MTIME_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next prescaler count: wrap on the tick cycle, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_smp.sv
// clint_smp: core-local interruptor for an N_HARTS SMP cluster.
//   One free-running 64-bit mtime, per-hart mtimecmp and msip, reached
//   through a 32-bit word-access slave port with a fixed one-cycle ack.
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   w_re, w_we         single-cycle read / write request (write wins if both)
//   w_addr             byte offset in the CLINT window, bits [1:0] ignored
//   w_wdata            write data
//   w_rdata, w_ack     registered read data (0 when no ack) and acknowledge
//   w_mtip, w_msip     per-hart timer / software interrupt pending
//   w_mtime            current mtime
module clint_smp
  import clint_pkg::*;
#(
  parameter int          N_HARTS   = 1,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               w_re,
  input  logic               w_we,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  output logic [31:0]        w_rdata,
  output logic               w_ack,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [63:0]        w_mtime
);

  logic               tick_s;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q [N_HARTS];
  logic [63:0]        mtimecmp_d [N_HARTS];
  logic [N_HARTS-1:0] msip_q, msip_d;
  logic [N_HARTS-1:0] mtip_q, mtip_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q, ack_d;

  clint_sel_e         sel_s;
  logic [15:0]        msip_off_s;
  logic [15:0]        cmp_off_s;
  logic [13:0]        msip_h_s;
  logic [12:0]        cmp_h_s;
  logic               cmp_hi_s;
  logic               mtime_hi_s;
  logic               unused_s;

  clint_tick_gen #(
    .MTIME_DIV(MTIME_DIV)
  ) u_tick_gen (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_o(tick_s)
  );

  // Sub-word byte lanes of the region offsets carry no information.
  assign unused_s = ^{msip_off_s[1:0], cmp_off_s[1:0]};

  // Address decode: region select plus hart index and word half.
  always_comb begin
    msip_off_s = w_addr - CLINT_MSIP_BASE;
    cmp_off_s  = w_addr - CLINT_MTIMECMP_BASE;
    msip_h_s   = msip_off_s[15:2];
    cmp_h_s    = cmp_off_s[15:3];
    cmp_hi_s   = cmp_off_s[2];
    mtime_hi_s = word_match(w_addr, CLINT_MTIME_HI);
    sel_s      = SEL_NONE;
    if (w_addr < CLINT_MTIMECMP_BASE) begin
      sel_s = SEL_MSIP;
    end else if (w_addr < CLINT_MTIME_LO) begin
      sel_s = SEL_MTIMECMP;
    end else if (word_match(w_addr, CLINT_MTIME_LO) || mtime_hi_s) begin
      sel_s = SEL_MTIME;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Register-file next state: a write to one mtime half overrides the tick,
  // so the other half holds its pre-tick value and the increment is lost.
  always_comb begin
    mtime_d = tick_s ? (mtime_q + 64'd1) : mtime_q;
    msip_d  = msip_q;
    for (int h = 0; h < N_HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
    end
    if (w_we) begin
      case (sel_s)
        SEL_MSIP: begin
          for (int h = 0; h < N_HARTS; h++) begin
            msip_d[h] = (msip_h_s == 14'(h)) ? w_wdata[0] : msip_q[h];
          end
        end
        SEL_MTIMECMP: begin
          for (int h = 0; h < N_HARTS; h++) begin
            if (cmp_h_s == 13'(h)) begin
              if (cmp_hi_s) begin
                mtimecmp_d[h][63:32] = w_wdata;
              end else begin
                mtimecmp_d[h][31:0] = w_wdata;
              end
            end else begin
              mtimecmp_d[h] = mtimecmp_q[h];
            end
          end
        end
        SEL_MTIME: begin
          if (mtime_hi_s) begin
            mtime_d = {w_wdata, mtime_q[31:0]};
          end else begin
            mtime_d = {mtime_q[63:32], w_wdata};
          end
        end
        default: begin
          msip_d = msip_q;
        end
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Timer compare on current register values; result is registered.
  always_comb begin
    mtip_d = {N_HARTS{1'b0}};
    for (int h = 0; h < N_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  // Read mux and ack; a simultaneous write suppresses the read data.
  always_comb begin
    ack_d   = w_re | w_we;
    rdata_d = 32'd0;
    if (w_re && !w_we) begin
      case (sel_s)
        SEL_MSIP: begin
          for (int h = 0; h < N_HARTS; h++) begin
            rdata_d = (msip_h_s == 14'(h)) ? {31'd0, msip_q[h]} : rdata_d;
          end
        end
        SEL_MTIMECMP: begin
          for (int h = 0; h < N_HARTS; h++) begin
            rdata_d = (cmp_h_s == 13'(h)) ?
                      (cmp_hi_s ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0]) : rdata_d;
          end
        end
        SEL_MTIME: begin
          rdata_d = mtime_hi_s ? mtime_q[63:32] : mtime_q[31:0];
        end
        default: begin
          rdata_d = 32'd0;
        end
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State registers; reset drops any in-flight request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtime_q <= 64'd0;
      msip_q  <= {N_HARTS{1'b0}};
      mtip_q  <= {N_HARTS{1'b0}};
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp_q[h] <= MTIMECMP_RESET;
      end
    end else begin
      mtime_q <= mtime_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign w_rdata = rdata_q;
  assign w_ack   = ack_q;
  assign w_mtip  = mtip_q;
  assign w_msip  = msip_q;
  assign w_mtime = mtime_q;

endmodule
